// File: rtl/split_initiator_port.sv
// Initiator end of the split-capable serial bus: takes one parallel request, wins the bus,
// and shifts the address and write data out LSB-first, or collects a read byte (with split resume).
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | no transaction; waiting for init_req
// S_REQ        | arbiter_req high, waiting for grant and target ready
// S_ADDR       | shifting 16 address bits out, LSB-first
// S_DATA       | shifting 8 write-data bits out, LSB-first
// S_WACK       | write sent, waiting for target acknowledge
// S_RDATA      | collecting 8 read bits from the target
// S_SPLIT_WAIT | bus released after split; waiting for split_grant
module split_initiator_port #(
    parameter int TIMEOUT = 64,
    parameter int TIMER_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_req,
    input  logic [15:0] init_addr,
    input  logic [7:0]  init_wdata,
    input  logic        init_rw,
    output logic        init_busy,
    output logic [7:0]  init_rdata,
    output logic        init_done,
    output logic        init_error,
    output logic        init_split,
    output logic        arbiter_req,
    input  logic        arbiter_grant,
    input  logic        split_grant,
    output logic        bus_data_out,
    output logic        bus_data_out_valid,
    output logic        bus_mode,
    output logic        bus_rw,
    input  logic        bus_data_in,
    input  logic        bus_data_in_valid,
    input  logic        bus_target_ready,
    input  logic        bus_split_ack,
    input  logic        bus_target_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_DATA,
        S_WACK,
        S_RDATA,
        S_SPLIT_WAIT
    } state_t;

    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT - 1);

    state_t             state;
    logic [15:0]        addr_sh;
    logic [7:0]         wdata_sh;
    logic [7:0]         rd_sh;
    logic [3:0]         bit_cnt;
    logic [TIMER_W-1:0] timer;
    logic               timeout_hit;

    assign timeout_hit = (timer == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            addr_sh            <= '0;
            wdata_sh           <= '0;
            rd_sh              <= '0;
            bit_cnt            <= '0;
            timer              <= '0;
            init_busy          <= 1'b0;
            init_rdata         <= '0;
            init_done          <= 1'b0;
            init_error         <= 1'b0;
            init_split         <= 1'b0;
            arbiter_req        <= 1'b0;
            bus_data_out       <= 1'b0;
            bus_data_out_valid <= 1'b0;
            bus_mode           <= 1'b0;
            bus_rw             <= 1'b0;
        end else begin
            // Pulses default low; the timer restarts on every state entry.
            init_done  <= 1'b0;
            init_error <= 1'b0;
            timer      <= '0;

            case (state)
                S_IDLE: begin
                    // A request coinciding with the completion pulse is dropped.
                    if (init_req && !init_done) begin
                        addr_sh     <= init_addr;
                        wdata_sh    <= init_wdata;
                        bus_rw      <= init_rw;
                        arbiter_req <= 1'b1;
                        init_busy   <= 1'b1;
                        state       <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (arbiter_grant && bus_target_ready) begin
                        bus_data_out       <= addr_sh[0];
                        addr_sh            <= {1'b0, addr_sh[15:1]};
                        bus_data_out_valid <= 1'b1;
                        bus_mode           <= 1'b0;
                        bit_cnt            <= '0;
                        state              <= S_ADDR;
                    end else if (timeout_hit) begin
                        init_done   <= 1'b1;
                        init_error  <= 1'b1;
                        arbiter_req <= 1'b0;
                        init_busy   <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_ADDR: begin
                    if (!arbiter_grant) begin
                        init_done          <= 1'b1;
                        init_error         <= 1'b1;
                        arbiter_req        <= 1'b0;
                        init_busy          <= 1'b0;
                        bus_data_out       <= 1'b0;
                        bus_data_out_valid <= 1'b0;
                        bus_mode           <= 1'b0;
                        bit_cnt            <= '0;
                        state              <= S_IDLE;
                    end else if (bit_cnt == 4'd15) begin
                        bit_cnt <= '0;
                        if (bus_rw) begin
                            bus_data_out <= wdata_sh[0];
                            wdata_sh     <= {1'b0, wdata_sh[7:1]};
                            bus_mode     <= 1'b1;
                            state        <= S_DATA;
                        end else begin
                            bus_data_out       <= 1'b0;
                            bus_data_out_valid <= 1'b0;
                            rd_sh              <= '0;
                            state              <= S_RDATA;
                        end
                    end else begin
                        bus_data_out <= addr_sh[0];
                        addr_sh      <= {1'b0, addr_sh[15:1]};
                        bit_cnt      <= bit_cnt + 4'd1;
                    end
                end

                S_DATA: begin
                    if (!arbiter_grant) begin
                        init_done          <= 1'b1;
                        init_error         <= 1'b1;
                        arbiter_req        <= 1'b0;
                        init_busy          <= 1'b0;
                        bus_data_out       <= 1'b0;
                        bus_data_out_valid <= 1'b0;
                        bus_mode           <= 1'b0;
                        bit_cnt            <= '0;
                        state              <= S_IDLE;
                    end else if (bit_cnt == 4'd7) begin
                        bus_data_out       <= 1'b0;
                        bus_data_out_valid <= 1'b0;
                        bus_mode           <= 1'b0;
                        bit_cnt            <= '0;
                        state              <= S_WACK;
                    end else begin
                        bus_data_out <= wdata_sh[0];
                        wdata_sh     <= {1'b0, wdata_sh[7:1]};
                        bit_cnt      <= bit_cnt + 4'd1;
                    end
                end

                S_WACK: begin
                    if (bus_target_ack) begin
                        init_done   <= 1'b1;
                        arbiter_req <= 1'b0;
                        init_busy   <= 1'b0;
                        state       <= S_IDLE;
                    end else if (timeout_hit) begin
                        init_done   <= 1'b1;
                        init_error  <= 1'b1;
                        arbiter_req <= 1'b0;
                        init_busy   <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_RDATA: begin
                    // Bits enter at the top so bit k lands in position k after eight shifts.
                    if (bus_data_in_valid && bit_cnt == 4'd7) begin
                        init_rdata  <= {bus_data_in, rd_sh[7:1]};
                        init_done   <= 1'b1;
                        arbiter_req <= 1'b0;
                        init_busy   <= 1'b0;
                        bit_cnt     <= '0;
                        state       <= S_IDLE;
                    end else if (bus_split_ack && bit_cnt == 4'd0) begin
                        arbiter_req <= 1'b0;
                        init_split  <= 1'b1;
                        state       <= S_SPLIT_WAIT;
                    end else if (timeout_hit) begin
                        init_done   <= 1'b1;
                        init_error  <= 1'b1;
                        arbiter_req <= 1'b0;
                        init_busy   <= 1'b0;
                        bit_cnt     <= '0;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                        if (bus_data_in_valid) begin
                            rd_sh   <= {bus_data_in, rd_sh[7:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end

                S_SPLIT_WAIT: begin
                    if (split_grant) begin
                        init_split  <= 1'b0;
                        arbiter_req <= 1'b1;
                        rd_sh       <= '0;
                        bit_cnt     <= '0;
                        state       <= S_RDATA;
                    end else if (timeout_hit) begin
                        init_done  <= 1'b1;
                        init_error <= 1'b1;
                        init_split <= 1'b0;
                        init_busy  <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_split_initiator_port.sv
// Directed bench for split_initiator_port: serial bits and completions are predicted into
// scoreboard queues as stimulus is driven and checked when the port produces them.
module tb_split_initiator_port;

    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst_n;
    logic        init_req;
    logic [15:0] init_addr;
    logic [7:0]  init_wdata;
    logic        init_rw;
    logic        init_busy;
    logic [7:0]  init_rdata;
    logic        init_done;
    logic        init_error;
    logic        init_split;
    logic        arbiter_req;
    logic        arbiter_grant;
    logic        split_grant;
    logic        bus_data_out;
    logic        bus_data_out_valid;
    logic        bus_mode;
    logic        bus_rw;
    logic        bus_data_in;
    logic        bus_data_in_valid;
    logic        bus_target_ready;
    logic        bus_split_ack;
    logic        bus_target_ack;

    split_initiator_port #(.TIMEOUT(TIMEOUT), .TIMER_W(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .init_req          (init_req),
        .init_addr         (init_addr),
        .init_wdata        (init_wdata),
        .init_rw           (init_rw),
        .init_busy         (init_busy),
        .init_rdata        (init_rdata),
        .init_done         (init_done),
        .init_error        (init_error),
        .init_split        (init_split),
        .arbiter_req       (arbiter_req),
        .arbiter_grant     (arbiter_grant),
        .split_grant       (split_grant),
        .bus_data_out      (bus_data_out),
        .bus_data_out_valid(bus_data_out_valid),
        .bus_mode          (bus_mode),
        .bus_rw            (bus_rw),
        .bus_data_in       (bus_data_in),
        .bus_data_in_valid (bus_data_in_valid),
        .bus_target_ready  (bus_target_ready),
        .bus_split_ack     (bus_split_ack),
        .bus_target_ack    (bus_target_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic       chk_rdata;
        logic [7:0] rdata;
    } done_t;

    logic [1:0] bit_q[$];
    done_t      done_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_rdata = 8'h00;
    int         cyc;

    logic [16:0] outs;
    assign outs = {init_busy, init_rdata, init_done, init_error, init_split, arbiter_req,
                   bus_data_out, bus_data_out_valid, bus_mode, bus_rw};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_addr(input logic [15:0] a, input int n);
        for (int i = 0; i < n; i++) bit_q.push_back({1'b0, a[i]});
    endtask

    task automatic push_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) bit_q.push_back({1'b1, d[i]});
    endtask

    task automatic push_done(input logic err, input logic chk, input logic [7:0] rd);
        done_t d;
        d.err = err;
        d.chk_rdata = chk;
        d.rdata = rd;
        done_q.push_back(d);
    endtask

    task automatic request(input logic [15:0] a, input logic [7:0] d, input logic rw);
        tick();
        init_addr  = a;
        init_wdata = d;
        init_rw    = rw;
        init_req   = 1'b1;
        tick();
        init_req = 1'b0;
        check("req_raised", {31'b0, arbiter_req}, 1);
        check("bus_rw_latched", {31'b0, bus_rw}, {31'b0, rw});
    endtask

    task automatic run_bits(input int n);
        int got;
        int guard;
        logic [1:0] exp;
        got = 0;
        guard = 0;
        while (got < n && guard < 200) begin
            tick();
            guard++;
            if (bus_data_out_valid) begin
                if (bit_q.size() == 0) begin
                    check("serial_unexpected", {30'b0, bus_mode, bus_data_out}, 32'hFFFF_FFFF);
                end else begin
                    exp = bit_q.pop_front();
                    check("serial_bit", {30'b0, bus_mode, bus_data_out}, {30'b0, exp});
                end
                got++;
            end
        end
        if (got < n) check("serial_timeout", got, n);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic gaps);
        for (int i = 0; i < 8; i++) begin
            bus_data_in       = b[i];
            bus_data_in_valid = 1'b1;
            tick();
            bus_data_in_valid = 1'b0;
            bus_data_in       = 1'b0;
            if (gaps && i != 7) repeat (i % 3) tick();
        end
    endtask

    task automatic wait_done(input int budget, output int n);
        done_t exp;
        n = 0;
        while (!init_done && n < budget) begin
            tick();
            n++;
        end
        if (!init_done) begin
            check("done_timeout", {31'b0, init_done}, 1);
            if (done_q.size() != 0) exp = done_q.pop_front();
        end else if (done_q.size() == 0) begin
            check("done_unexpected", {31'b0, init_done}, 0);
        end else begin
            exp = done_q.pop_front();
            check("done_error", {31'b0, init_error}, {31'b0, exp.err});
            if (exp.chk_rdata) check("done_rdata", {24'b0, init_rdata}, {24'b0, exp.rdata});
            check("done_arb_req_low", {31'b0, arbiter_req}, 0);
            check("done_busy_low", {31'b0, init_busy}, 0);
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        init_req          = 1'b0;
        init_addr         = '0;
        init_wdata        = '0;
        init_rw           = 1'b0;
        arbiter_grant     = 1'b1;
        split_grant       = 1'b0;
        bus_data_in       = 1'b0;
        bus_data_in_valid = 1'b0;
        bus_target_ready  = 1'b1;
        bus_split_ack     = 1'b0;
        bus_target_ack    = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {15'b0, outs}, 0);
        rst_n = 1'b1;

        // Write 0x1234 / 0xA5, ack in the third WACK cycle
        request(16'h1234, 8'hA5, 1'b1);
        push_addr(16'h1234, 16);
        push_data(8'hA5);
        run_bits(24);
        tick();
        check("wack_valid_low", {31'b0, bus_data_out_valid}, 0);
        tick();
        tick();
        bus_target_ack = 1'b1;
        push_done(1'b0, 1'b0, 8'h00);
        wait_done(10, cyc);
        bus_target_ack = 1'b0;
        check("write_ack_latency", cyc, 1);

        // Read 0x00FF returning 0x3C with gaps
        request(16'h00FF, 8'h00, 1'b0);
        push_addr(16'h00FF, 16);
        run_bits(16);
        tick();
        check("rdata_valid_low", {31'b0, bus_data_out_valid}, 0);
        send_byte(8'h3C, 1'b1);
        push_done(1'b0, 1'b1, 8'h3C);
        last_rdata = 8'h3C;
        wait_done(10, cyc);
        check("read_done_latency", cyc, 0);

        // Request raised in the same cycle as init_done is ignored
        init_addr = 16'hAAAA;
        init_rw   = 1'b0;
        init_req  = 1'b1;
        tick();
        init_req = 1'b0;
        check("req_during_done_ignored", {31'b0, init_busy}, 0);

        // Split read: release, park 20 cycles, resume and receive 0x81
        request(16'h4321, 8'h00, 1'b0);
        push_addr(16'h4321, 16);
        run_bits(16);
        tick();
        bus_split_ack = 1'b1;
        tick();
        bus_split_ack = 1'b0;
        check("split_arb_req_low", {31'b0, arbiter_req}, 0);
        check("split_flag", {31'b0, init_split}, 1);
        repeat (20) tick();
        check("split_hold", {31'b0, init_split}, 1);
        check("split_busy", {31'b0, init_busy}, 1);
        split_grant = 1'b1;
        tick();
        split_grant = 1'b0;
        check("resume_split_low", {31'b0, init_split}, 0);
        check("resume_arb_req", {31'b0, arbiter_req}, 1);
        send_byte(8'h81, 1'b0);
        push_done(1'b0, 1'b1, 8'h81);
        last_rdata = 8'h81;
        wait_done(10, cyc);
        check("split_read_latency", cyc, 0);

        // Write with no ack: timeout exactly TIMEOUT cycles after WACK entry
        request(16'hCAFE, 8'h3C, 1'b1);
        push_addr(16'hCAFE, 16);
        push_data(8'h3C);
        run_bits(24);
        tick();
        check("wack_entry_valid_low", {31'b0, bus_data_out_valid}, 0);
        push_done(1'b1, 1'b1, last_rdata);
        wait_done(200, cyc);
        check("wack_timeout_cycles", cyc, TIMEOUT);

        // Grant dropped while address bit 7 is on the wire
        request(16'hBEEF, 8'h00, 1'b0);
        push_addr(16'hBEEF, 8);
        run_bits(8);
        arbiter_grant = 1'b0;
        push_done(1'b1, 1'b1, last_rdata);
        wait_done(10, cyc);
        check("grant_loss_latency", cyc, 1);
        check("grant_loss_valid_low", {31'b0, bus_data_out_valid}, 0);
        arbiter_grant = 1'b1;

        // Reset in the middle of the data phase, then a clean write
        request(16'h5555, 8'hC3, 1'b1);
        push_addr(16'h5555, 16);
        push_data(8'hC3);
        run_bits(19);
        rst_n = 1'b0;
        #1;
        check("reset_mid_data", {15'b0, outs}, 0);
        bit_q.delete();
        tick();
        check("reset_no_done", {31'b0, init_done}, 0);
        rst_n = 1'b1;
        request(16'h0F0F, 8'h5A, 1'b1);
        push_addr(16'h0F0F, 16);
        push_data(8'h5A);
        run_bits(24);
        tick();
        bus_target_ack = 1'b1;
        push_done(1'b0, 1'b0, 8'h00);
        wait_done(10, cyc);
        bus_target_ack = 1'b0;
        check("post_reset_write_latency", cyc, 1);

        check("scoreboard_drained", bit_q.size() + done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
